// File: rtl/start_rdy_timer.sv
// One-shot START/RDY delay timer: latches DELAY on START, counts it down on a
// PRESCALE-cycle tick and answers with a one-cycle RDY. Optional TIMER_RETRIG_EN.
module start_rdy_timer #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             START,
    input  logic [WIDTH-1:0] DELAY,
    input  logic             ERR_CLR,
    output logic             RDY,
    output logic             BUSY,
    output logic [WIDTH-1:0] COUNT,
    output logic             ERR
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

`ifdef TIMER_RETRIG_EN
    localparam bit RETRIG_EN = 1'b1;
`else
    localparam bit RETRIG_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [PRE_W-1:0] pre_q;
    logic             err_q;

    logic tick;
    logic err_set;

    assign tick    = (pre_q == PRE_LAST);
    // A START that lands in RUN is a protocol error only when it cannot re-trigger.
    assign err_set = START && (state_q == RUN) && !RETRIG_EN;

    // NOTE: state registers use non-blocking assignments so every branch sees
    // the pre-edge values and the block models true flip-flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            pre_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (err_set) begin
                err_q <= 1'b1;
            end else if (ERR_CLR) begin
                err_q <= 1'b0;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (START) begin
                        count_q <= DELAY;
                        pre_q   <= '0;
                        state_q <= (DELAY == '0) ? DONE : RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (START && RETRIG_EN) begin
                        count_q <= DELAY;
                        pre_q   <= '0;
                        state_q <= (DELAY == '0) ? DONE : RUN;
                    end else if (tick) begin
                        pre_q <= '0;
                        if (count_q != '0) begin
                            count_q <= count_q - WIDTH'(1);
                        end
                        if (count_q <= WIDTH'(1)) begin
                            state_q <= DONE;
                        end
                    end else begin
                        pre_q <= pre_q + PRE_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Moore outputs decoded straight from registers; no path from START.
    assign RDY   = (state_q == DONE);
    assign BUSY  = (state_q != IDLE);
    assign COUNT = count_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_start_rdy_timer.sv
// Self-checking bench for start_rdy_timer: timeline model compared every cycle
// plus directed latency/level checks. Honours TIMER_RETRIG_EN if defined.
module tb_start_rdy_timer;

    localparam int WIDTH    = 16;
    localparam int PRESCALE = 4;

`ifdef TIMER_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             START = 1'b0;
    logic [WIDTH-1:0] DELAY = '0;
    logic             ERR_CLR = 1'b0;
    logic             RDY;
    logic             BUSY;
    logic [WIDTH-1:0] COUNT;
    logic             ERR;

    int n_checks = 0;
    int n_errors = 0;

    start_rdy_timer #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
        .clk    (clk),
        .reset  (reset),
        .START  (START),
        .DELAY  (DELAY),
        .ERR_CLR(ERR_CLR),
        .RDY    (RDY),
        .BUSY   (BUSY),
        .COUNT  (COUNT),
        .ERR    (ERR)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Timeline model: an accepted start at edge s with delay d means the
    // outputs after edge e show d - (e-s)/PRESCALE until edge s + d*PRESCALE,
    // where RDY appears for one cycle.
    longint e;
    longint m_start;
    longint m_rdy_edge;
    longint m_d;
    bit     m_active;
    bit     m_rdy;
    bit     m_busy;
    bit     m_err;
    longint m_count;
    bit     in_run;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            e = 0; m_active = 0; m_rdy = 0; m_busy = 0; m_err = 0; m_count = 0;
            m_start = 0; m_rdy_edge = 0; m_d = 0;
        end else begin
            e++;
            in_run = m_busy && !m_rdy;
            if (START && (!in_run || RETRIG)) begin
                m_active   = 1;
                m_start    = e;
                m_d        = longint'(DELAY);
                m_rdy_edge = e + m_d * PRESCALE;
            end
            if (START && in_run && !RETRIG) m_err = 1;
            else if (ERR_CLR) m_err = 0;
            if (m_active && e < m_rdy_edge) begin
                m_busy = 1; m_rdy = 0; m_count = m_d - (e - m_start) / PRESCALE;
            end else if (m_active && e == m_rdy_edge) begin
                m_busy = 1; m_rdy = 1; m_count = 0;
            end else begin
                m_active = 0; m_busy = 0; m_rdy = 0; m_count = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("model RDY", RDY, m_rdy);
            check("model BUSY", BUSY, m_busy);
            check("model COUNT", COUNT, m_count);
            check("model ERR", ERR, m_err);
        end
    end

    task automatic pulse_start(input logic [WIDTH-1:0] d);
        @(posedge clk);
        #1 START = 1'b1; DELAY = d;
        @(posedge clk);
        #1 START = 1'b0;
    endtask

    // Counts negedges from the first one after the accepting edge until RDY.
    task automatic wait_rdy(input int budget, output int lat, output int first_count);
        lat = -1;
        first_count = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i == 0) first_count = int'(COUNT);
            if (RDY) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int lat;
    int fc;
    int rdy_seen;

    initial begin
        #2 check("reset RDY", RDY, 0);
        check("reset BUSY", BUSY, 0);
        check("reset COUNT", COUNT, 0);
        check("reset ERR", ERR, 0);
        #20 reset = 1'b1;

        // Basic delay D=3: latency 12, COUNT starts at 3, one-cycle RDY.
        pulse_start(16'd3);
        wait_rdy(40, lat, fc);
        check("basic latency", lat, 12);
        check("basic first COUNT", fc, 3);
        @(negedge clk);
        check("basic RDY width", RDY, 0);
        check("basic BUSY fall", BUSY, 0);

        // Zero delay.
        pulse_start(16'd0);
        wait_rdy(10, lat, fc);
        check("zero latency", lat, 0);
        @(negedge clk);
        check("zero BUSY one cycle", BUSY, 0);
        check("zero ERR", ERR, 0);

        // Back-to-back: restart during the RDY cycle with D=2.
        pulse_start(16'd1);
        wait_rdy(20, lat, fc);
        check("b2b first latency", lat, 4);
        START = 1'b1; DELAY = 16'd2;
        @(posedge clk);
        #1 START = 1'b0;
        wait_rdy(40, lat, fc);
        check("b2b second latency", lat, 8);
        check("b2b first COUNT", fc, 2);
        repeat (3) @(negedge clk);

        // Mid-run START after two ticks of D=3.
        pulse_start(16'd3);
        repeat (8) @(posedge clk);
        #1 START = 1'b1; DELAY = 16'd5;
        @(posedge clk);
        #1 START = 1'b0;
        wait_rdy(60, lat, fc);
        check("midrun latency", lat, RETRIG ? 20 : 3);
        check("midrun COUNT", fc, RETRIG ? 5 : 1);
        check("midrun ERR", ERR, RETRIG ? 0 : 1);
        @(negedge clk);
        ERR_CLR = 1'b1;
        @(posedge clk);
        #1 ERR_CLR = 1'b0;
        @(negedge clk);
        check("ERR_CLR clears", ERR, 0);

        // START in RUN with ERR_CLR on the same edge: set wins.
        pulse_start(16'd2);
        @(negedge clk);
        START = 1'b1; DELAY = 16'd2; ERR_CLR = 1'b1;
        @(posedge clk);
        #1 START = 1'b0; ERR_CLR = 1'b0;
        @(negedge clk);
        check("set beats clear", ERR, RETRIG ? 0 : 1);
        wait_rdy(40, lat, fc);
        check("set-wins run completes", lat >= 0, 1);
        ERR_CLR = 1'b1;
        @(posedge clk);
        #1 ERR_CLR = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-RUN at COUNT=2: outputs clear without a clock edge.
        pulse_start(16'd3);
        repeat (4) @(posedge clk);
        #2 check("pre-reset COUNT", COUNT, 2);
        #1 reset = 1'b0;
        #1 check("async RDY", RDY, 0);
        check("async BUSY", BUSY, 0);
        check("async COUNT", COUNT, 0);
        check("async ERR", ERR, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (RDY) rdy_seen++;
        end
        check("no RDY after reset", rdy_seen, 0);

        // Controller loop: X=1 then X=0 each issue one START and await RDY.
        pulse_start(16'd2);
        wait_rdy(40, lat, fc);
        check("ctrl X=1 latency", lat, 8);
        repeat (5) @(negedge clk);
        pulse_start(16'd5);
        wait_rdy(60, lat, fc);
        check("ctrl X=0 latency", lat, 20);
        check("ctrl ERR", ERR, 0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/start_rdy_timer.md
# start_rdy_timer

Programmable one-shot delay timer that acts as the responder side of the START/RDY handshake used by the timer-task Moore controllers. A controller pulses START; the block latches a delay value, counts it down on a prescaled tick, and returns a single-cycle RDY pulse when the delay has elapsed. It sits between each controller FSM and the shared clock. It also provides busy, remaining-count and protocol-error status for debug and for the verification bench.

## Interface
- WIDTH, 16: width of DELAY and COUNT, in ticks.
- PRESCALE, 4: clock cycles per tick, must be ≥1. A value of 1 gives one tick per cycle. The prescaler counter is $clog2(PRESCALE) bits wide, minimum 1 bit.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; reset == 0 forces the reset state immediately, independent of clk.
- START  input  1  start request from controller, sampled on each rising clk edge; single-cycle pulse expected, level tolerated.
- DELAY  input  WIDTH  delay in ticks, sampled only in the cycle a START is accepted.
- ERR_CLR  input  1  synchronous clear of ERR.
- RDY  output  1  one-cycle completion pulse (Moore, decoded from state).
- BUSY  output  1  high whenever state is not IDLE.
- COUNT  output  WIDTH  remaining ticks (count register).
- ERR  output  1  sticky protocol error: START received while RUN.

## Operation
- States: IDLE, RUN, DONE. Registers: state, count (WIDTH), pre (prescaler), err.
- Reset values: state = IDLE, count = 0, pre = 0, err = 0; RDY = 0, BUSY = 0, COUNT = 0, ERR = 0.
- IDLE: on START = 1, load count ← DELAY and pre ← 0.
  - If DELAY ≠ 0, go to RUN.
  - If DELAY = 0, go directly to DONE.
  - Otherwise stay in IDLE.
- RUN, tick rule: a tick occurs on each edge where pre == PRESCALE−1. On a tick, pre ← 0 and count ← count−1. Otherwise pre ← pre+1.
- RUN, exit: on a tick with count == 1, go to DONE. count becomes 0.
- DONE: RDY = 1 for exactly this one cycle.
  - START = 1 in DONE is accepted as a new start, using the same load rules as IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- START while RUN: behaviour depends on TIMER_RETRIG_EN (see Configuration).
- ERR: set on a rejected START. Cleared by ERR_CLR = 1. If a set and a clear occur on the same edge, set wins.
- Count never wraps: decrement occurs only in RUN with count ≥ 1. DELAY = all-ones is legal and gives the maximum delay.
- Reset asserted mid-RUN or mid-DONE: outputs return to their reset values immediately. No RDY is emitted for the aborted delay.

## Timing
- Define edge k as the edge where START is accepted from IDLE with DELAY = D > 0:
  - BUSY rises after edge k.
  - RDY is high in the cycle following edge k + D·PRESCALE.
  - BUSY falls one cycle after RDY rises.
  - Total latency from BUSY rise to RDY rise is D·PRESCALE cycles.
- D = 0: RDY is high in the cycle right after edge k.
- COUNT reflects the register value: it shows D in the cycle after edge k and decrements every PRESCALE cycles.
- RDY and BUSY are Moore outputs with no combinational path from START.

## Configuration
- Macro: TIMER_RETRIG_EN.
- Defined: START in RUN re-triggers. It reloads count ← DELAY and pre ← 0. If the new DELAY is 0, go to DONE. ERR is never set.
- Undefined: START in RUN is ignored. count and pre are unaffected, and ERR ← 1.

## Test plan
- Basic delay: PRESCALE = 4, pulse START with DELAY = 3 → BUSY high next cycle, RDY high for exactly 1 cycle 12 cycles after BUSY rises, COUNT steps 3, 2, 1, 0, then back to IDLE.
- Zero delay: START with DELAY = 0 → RDY high the very next cycle for 1 cycle, BUSY high 1 cycle, ERR = 0.
- Back-to-back: START asserted again during the RDY cycle with DELAY = 2 → RDY pulses, BUSY stays high, second RDY 8 cycles later.
- Mid-run START: START in RUN with DELAY = 5, after 2 ticks of an initial DELAY = 3:
  - Macro off: RDY at the original time and ERR = 1; ERR_CLR clears it.
  - Macro on: COUNT reloads to 5, RDY 20 cycles after the re-trigger, ERR = 0.
- Reset mid-operation: drop reset during RUN at COUNT = 2 → RDY, BUSY, COUNT and ERR go to 0 without a clk edge, and no RDY appears after reset releases.
- Controller loop: connect to the START/RDY controller FSM, drive X = 1 then later X = 0 → two START pulses, each answered by one RDY after DELAY·PRESCALE cycles, ERR = 0 throughout.
